// File: rtl/stopwatch_ctrl_pkg.sv
// Shared types and constants for the stopwatch controller and its decade counters.
package stopwatch_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RUN      = 2'd1,
    ST_LAP_HOLD = 2'd2,
    ST_STOP     = 2'd3
  } sw_state_t;

  localparam int              BCD_W   = 4;
  localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

endpackage

// File: rtl/bcd_digit.sv
// Single decade counter: counts 0..9 when enabled, carry out on the 9->0 step.
module bcd_digit
  import stopwatch_ctrl_pkg::*;
(
  input  logic             CLK,
  input  logic             RESET_B,
  input  logic             CLR,
  input  logic             EN,
  output logic [BCD_W-1:0] Q,
  output logic             CO
);

  logic [BCD_W-1:0] r_q;

  always_ff @(posedge CLK or negedge RESET_B) begin
    if (!RESET_B) begin
      r_q <= '0;
    end else if (CLR) begin
      r_q <= '0;
    end else if (EN) begin
      r_q <= (r_q == BCD_MAX) ? '0 : r_q + 4'd1;
    end
  end

  assign Q  = r_q;
  assign CO = EN & (r_q == BCD_MAX);

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch controller: cascaded BCD count with run/stop, lap snapshot and sticky wrap flag.
//   state    | meaning
//   IDLE     | count zeroed, waiting for START_STOP
//   RUN      | counting, live count shown
//   LAP_HOLD | counting continues, snapshot shown
//   STOP     | count frozen and shown
module stopwatch_ctrl
  import stopwatch_ctrl_pkg::*;
#(
  parameter int NDIG = 4
) (
  input  logic                  CLK,
  input  logic                  RESET_B,
  input  logic                  TICK,
  input  logic                  START_STOP,
  input  logic                  LAP,
  input  logic                  CLEAR,
  output logic [BCD_W*NDIG-1:0] DISP,
  output logic                  RUNNING,
  output logic                  HOLD,
  output logic                  OVF
);

  sw_state_t               r_state;
  sw_state_t               w_state_nxt;
  logic [BCD_W*NDIG-1:0]   r_snap;
  logic [BCD_W*NDIG-1:0]   w_count;
  logic [NDIG:0]           w_en;
  logic                    r_ovf;
  logic                    w_adv;
  logic                    w_zero;
  logic                    w_snap_ld;

  always_ff @(posedge CLK or negedge RESET_B) begin
    if (!RESET_B) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // CLEAR beats START_STOP beats LAP; a lower-priority pulse is dropped.
  always_comb begin
    w_state_nxt = r_state;
    w_zero      = 1'b0;
    w_snap_ld   = 1'b0;
    if (CLEAR) begin
      w_state_nxt = ST_IDLE;
      w_zero      = 1'b1;
    end else if (START_STOP) begin
      case (r_state)
        ST_IDLE:     w_state_nxt = ST_RUN;
        ST_RUN:      w_state_nxt = ST_STOP;
        ST_LAP_HOLD: w_state_nxt = ST_STOP;
        ST_STOP:     w_state_nxt = ST_RUN;
        default:     w_state_nxt = ST_IDLE;
      endcase
    end else if (LAP) begin
      case (r_state)
        ST_RUN: begin
          w_state_nxt = ST_LAP_HOLD;
          w_snap_ld   = 1'b1;
        end
        ST_LAP_HOLD: w_state_nxt = ST_RUN;
        ST_STOP: begin
          w_state_nxt = ST_IDLE;
          w_zero      = 1'b1;
        end
        default: w_state_nxt = r_state;
      endcase
    end
  end

  // A TICK alongside START_STOP in RUN still counts because only the pre-edge state matters.
  assign w_adv   = TICK & ~CLEAR & ((r_state == ST_RUN) | (r_state == ST_LAP_HOLD));
  assign w_en[0] = w_adv;

  for (genvar k = 0; k < NDIG; k++) begin : g_dig
    bcd_digit u_dig (
      .CLK     (CLK),
      .RESET_B (RESET_B),
      .CLR     (w_zero),
      .EN      (w_en[k]),
      .Q       (w_count[BCD_W*k +: BCD_W]),
      .CO      (w_en[k+1])
    );
  end

  always_ff @(posedge CLK or negedge RESET_B) begin
    if (!RESET_B) begin
      r_snap <= '0;
    end else if (CLEAR) begin
      r_snap <= '0;
    end else if (w_snap_ld) begin
      r_snap <= w_count;
    end
  end

  // Top digit carry means the whole count just wrapped from all 9s.
  always_ff @(posedge CLK or negedge RESET_B) begin
    if (!RESET_B) begin
      r_ovf <= 1'b0;
    end else if (w_zero) begin
      r_ovf <= 1'b0;
    end else if (w_en[NDIG]) begin
      r_ovf <= 1'b1;
    end
  end

  assign DISP    = (r_state == ST_LAP_HOLD) ? r_snap : w_count;
  assign RUNNING = (r_state == ST_RUN) | (r_state == ST_LAP_HOLD);
  assign HOLD    = (r_state == ST_LAP_HOLD);
  assign OVF     = r_ovf;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Scoreboard bench for stopwatch_ctrl: an integer reference model pushes expected outputs per cycle.
module tb_stopwatch_ctrl;

  localparam int NDIG = 4;
  localparam int W    = 4 * NDIG;
  localparam int MODV = 10000;

  logic         CLK = 1'b0;
  logic         RESET_B = 1'b0;
  logic         TICK = 1'b0;
  logic         START_STOP = 1'b0;
  logic         LAP = 1'b0;
  logic         CLEAR = 1'b0;
  logic [W-1:0] DISP;
  logic         RUNNING;
  logic         HOLD;
  logic         OVF;

  int n_chk = 0;
  int n_err = 0;

  // model: 0 idle, 1 run, 2 hold, 3 stop
  int m_state = 0;
  int m_cnt   = 0;
  int m_snap  = 0;
  int m_ovf   = 0;

  logic [W+2:0] exp_q[$];

  stopwatch_ctrl #(.NDIG(NDIG)) dut (
    .CLK        (CLK),
    .RESET_B    (RESET_B),
    .TICK       (TICK),
    .START_STOP (START_STOP),
    .LAP        (LAP),
    .CLEAR      (CLEAR),
    .DISP       (DISP),
    .RUNNING    (RUNNING),
    .HOLD       (HOLD),
    .OVF        (OVF)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [W-1:0] to_bcd(input int v);
    logic [W-1:0] r;
    int x;
    r = '0;
    x = v;
    for (int i = 0; i < NDIG; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic logic [W+2:0] model_out();
    logic [W-1:0] d;
    d = (m_state == 2) ? to_bcd(m_snap) : to_bcd(m_cnt);
    return {d, 1'(m_state == 1 || m_state == 2), 1'(m_state == 2), 1'(m_ovf != 0)};
  endfunction

  task automatic model_step(input logic t, input logic ss, input logic lp, input logic cl);
    int old_cnt;
    old_cnt = m_cnt;
    if (cl) begin
      m_state = 0; m_cnt = 0; m_snap = 0; m_ovf = 0;
    end else begin
      if (t && (m_state == 1 || m_state == 2)) begin
        m_cnt = m_cnt + 1;
        if (m_cnt == MODV) begin
          m_cnt = 0;
          m_ovf = 1;
        end
      end
      if (ss) begin
        m_state = (m_state == 0 || m_state == 3) ? 1 : 3;
      end else if (lp) begin
        if (m_state == 1) begin
          m_state = 2;
          m_snap  = old_cnt;
        end else if (m_state == 2) begin
          m_state = 1;
        end else if (m_state == 3) begin
          m_state = 0;
          m_cnt   = 0;
          m_ovf   = 0;
        end
      end
    end
  endtask

  task automatic step(input logic t, input logic ss, input logic lp, input logic cl);
    logic [W+2:0] e;
    @(negedge CLK);
    TICK = t; START_STOP = ss; LAP = lp; CLEAR = cl;
    model_step(t, ss, lp, cl);
    exp_q.push_back(model_out());
    @(posedge CLK);
    #1;
    if (exp_q.size() == 0) begin
      chk("sb_empty", 64'd0, 64'd1);
    end else begin
      e = exp_q.pop_front();
      chk("step", 64'({DISP, RUNNING, HOLD, OVF}), 64'(e));
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    #1;
    chk("rst_disp", 64'(DISP), 64'd0);
    chk("rst_flags", 64'({RUNNING, HOLD, OVF}), 64'd0);
    @(negedge CLK);
    RESET_B = 1'b1;

    step(1'b1, 1'b0, 1'b0, 1'b0);
    chk("idle_tick", 64'(DISP), 64'd0);

    step(1'b0, 1'b1, 1'b0, 1'b0);
    ticks(25);
    chk("run25_disp", 64'(DISP), 64'h0025);
    chk("run25_running", 64'(RUNNING), 64'd1);

    ticks(98);
    chk("pre_lap", 64'(DISP), 64'h0123);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    ticks(10);
    chk("lap_disp", 64'(DISP), 64'h0123);
    chk("lap_hold", 64'(HOLD), 64'd1);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    chk("lap_release", 64'(DISP), 64'h0133);

    step(1'b1, 1'b1, 1'b0, 1'b1);
    chk("clr_prio_disp", 64'(DISP), 64'd0);
    chk("clr_prio_run", 64'({RUNNING, HOLD}), 64'd0);

    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    chk("tick_ss_run", 64'({DISP, RUNNING}), 64'({16'h0001, 1'b0}));
    step(1'b1, 1'b1, 1'b0, 1'b0);
    chk("tick_ss_stop", 64'({DISP, RUNNING}), 64'({16'h0001, 1'b1}));
    step(1'b0, 1'b1, 1'b1, 1'b0);
    chk("ss_over_lap", 64'({RUNNING, HOLD}), 64'd0);

    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    ticks(10);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    ticks(5);
    chk("stop_frozen", 64'(DISP), 64'h0010);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    chk("stop_lap_zero", 64'({DISP, RUNNING}), 64'd0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    chk("idle_then_run", 64'(DISP), 64'h0001);

    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    ticks(9998);
    chk("pre_wrap", 64'({DISP, OVF}), 64'({16'h9998, 1'b0}));
    ticks(2);
    chk("wrap_disp", 64'(DISP), 64'h0000);
    chk("wrap_ovf", 64'(OVF), 64'd1);
    ticks(3);
    chk("ovf_sticky", 64'({DISP, OVF}), 64'({16'h0003, 1'b1}));
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("clr_ovf", 64'({OVF, RUNNING}), 64'd0);

    step(1'b0, 1'b1, 1'b0, 1'b0);
    ticks(10000);
    chk("wrap2_ovf", 64'(OVF), 64'd1);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    chk("stop_lap_ovf", 64'({OVF, DISP}), 64'd0);

    step(1'b0, 1'b1, 1'b0, 1'b0);
    ticks(47);
    chk("pre_reset", 64'(DISP), 64'h0047);
    @(negedge CLK);
    RESET_B = 1'b0;
    #1;
    chk("async_rst_disp", 64'(DISP), 64'd0);
    chk("async_rst_flags", 64'({RUNNING, HOLD, OVF}), 64'd0);
    #2;
    RESET_B = 1'b1;
    m_state = 0; m_cnt = 0; m_snap = 0; m_ovf = 0;
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    chk("post_rst_idle", 64'({DISP, RUNNING}), 64'd0);

    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 15) == 0),
           1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 63) == 0));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
